wb_user_bridge: RTL



---
 rtl/wb_user_bridge_pkg.sv | 26 ++
 rtl/wb_user_bridge_timer.sv | 36 +++
 rtl/wb_user_bridge.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/wb_user_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Package  : j202_wb_pkg
// Purpose  : Shared types and constants for the user-area Wishbone bridge
// Revision : 1.0 - initial release
// ============================================================================
package j202_wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bridge_state_e;

  localparam logic [31:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;

  localparam int STATUS_MISS = 0;
  localparam int STATUS_TMO  = 1;

  // Channel index width; a single channel still needs a 1-bit index field.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_user_bridge_timer.sv
`default_nettype none
// ============================================================================
// Module   : wb_user_bridge_timer
// Purpose  : Loadable up-counter flagging the last cycle of an access window
// Revision : 1.0 - initial release
// ============================================================================
module wb_user_bridge_timer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [WIDTH-1:0] c_last = WIDTH'(TIMEOUT - 1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Asserted during the TIMEOUT-th enabled cycle, so the count reaches TIMEOUT at the edge.
  assign o_expire = i_en && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/wb_user_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wb_user_bridge
// Purpose  : Caravel Wishbone slave decoded onto NUM_TGT req/rdy target channels
// Revision : 1.0 - initial release
// ============================================================================
module wb_user_bridge
  import j202_wb_pkg::*;
#(
  parameter int          NUM_TGT   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          WIN_W     = 16,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DFLT
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_TGT-1:0]      tgt_req_o,
  output logic                    tgt_we_o,
  output logic [3:0]              tgt_sel_o,
  output logic [WIN_W-1:0]        tgt_adr_o,
  output logic [31:0]             tgt_wdata_o,
  input  logic [NUM_TGT*32-1:0]   tgt_rdata_i,
  input  logic [NUM_TGT-1:0]      tgt_rdy_i,
  output logic                    err_irq_o,
  output logic [1:0]              err_status_o,
  input  logic                    err_clr_i
);

  localparam int                 c_idxw    = idx_width(NUM_TGT);
  localparam int                 c_dec_lsb = WIN_W + c_idxw;
  localparam int                 c_tmr_w   = $clog2(TIMEOUT + 1);
  localparam logic [NUM_TGT-1:0] c_one     = NUM_TGT'(1);

  logic [31:0] w_rdata_ch [NUM_TGT];

  generate
    for (genvar g = 0; g < NUM_TGT; g++) begin : g_rdata_ch
      assign w_rdata_ch[g] = tgt_rdata_i[32*g +: 32];
    end
  endgenerate

  bridge_state_e       r_state;
  bridge_state_e       w_state_nxt;
  logic                r_hold;
  logic [c_idxw-1:0]   r_idx;
  logic [NUM_TGT-1:0]  r_req;
  logic [NUM_TGT-1:0]  w_req_nxt;
  logic                r_we;
  logic [3:0]          r_sel;
  logic [WIN_W-1:0]    r_adr;
  logic [31:0]         r_wdata;
  logic                r_ack;
  logic                w_ack_nxt;
  logic [31:0]         r_dat;
  logic [31:0]         w_dat_nxt;
  logic [1:0]          r_status;
  logic [1:0]          w_status_nxt;
  logic [1:0]          w_set;
  logic                r_irq;
  logic                w_latch;
  logic                w_tmr_load;
  logic                w_tmr_en;
  logic                w_tmr_expire;
  logic                w_hit;
  logic [c_idxw-1:0]   w_idx;

  assign w_hit = (wbs_adr_i[31:c_dec_lsb] == BASE_ADDR[31:c_dec_lsb]);
  assign w_idx = wbs_adr_i[c_dec_lsb-1:WIN_W];

  wb_user_bridge_timer #(
    .WIDTH   (c_tmr_w),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .i_load   (w_tmr_load),
    .i_en     (w_tmr_en),
    .o_expire (w_tmr_expire)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_ack_nxt   = 1'b0;
    w_dat_nxt   = '0;
    w_latch     = 1'b0;
    w_set       = '0;
    w_tmr_load  = 1'b0;
    w_tmr_en    = 1'b0;
    case (r_state)
      IDLE: begin
        w_tmr_load = 1'b1;
        w_req_nxt  = '0;
        // r_hold blanks the cycle after an ack so a strobe still held from it is not re-decoded.
        if (wbs_cyc_i && wbs_stb_i && !r_hold) begin
          w_latch = 1'b1;
          if (w_hit) begin
            w_state_nxt = ACCESS;
            w_req_nxt   = c_one << w_idx;
          end else begin
            w_state_nxt        = RESP;
            w_ack_nxt          = 1'b1;
            w_dat_nxt          = ERR_DATA;
            w_set[STATUS_MISS] = 1'b1;
          end
        end
      end
      ACCESS: begin
        w_tmr_en = 1'b1;
        if (!wbs_cyc_i) begin
          w_state_nxt = IDLE;
          w_req_nxt   = '0;
        end else if (tgt_rdy_i[r_idx]) begin
          w_state_nxt = RESP;
          w_req_nxt   = '0;
          w_ack_nxt   = 1'b1;
          w_dat_nxt   = r_we ? 32'd0 : w_rdata_ch[r_idx];
        end else if (w_tmr_expire) begin
          w_state_nxt       = RESP;
          w_req_nxt         = '0;
          w_ack_nxt         = 1'b1;
          w_dat_nxt         = ERR_DATA;
          w_set[STATUS_TMO] = 1'b1;
        end
      end
      RESP: begin
        w_tmr_load  = 1'b1;
        w_req_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_req_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A freshly recorded error outranks a clear arriving on the same edge.
  assign w_status_nxt = (err_clr_i ? 2'b00 : r_status) | w_set;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_hold   <= 1'b0;
      r_idx    <= '0;
      r_req    <= '0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_adr    <= '0;
      r_wdata  <= '0;
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_hold   <= (r_state == RESP);
      r_req    <= w_req_nxt;
      r_ack    <= w_ack_nxt;
      r_dat    <= w_dat_nxt;
      r_status <= w_status_nxt;
      r_irq    <= |w_status_nxt;
      if (w_latch) begin
        r_idx   <= w_idx;
        r_we    <= wbs_we_i;
        r_sel   <= wbs_sel_i;
        r_adr   <= wbs_adr_i[WIN_W-1:0];
        r_wdata <= wbs_dat_i;
      end
    end
  end

  assign wbs_ack_o    = r_ack;
  assign wbs_dat_o    = r_dat;
  assign tgt_req_o    = r_req;
  assign tgt_we_o     = r_we;
  assign tgt_sel_o    = r_sel;
  assign tgt_adr_o    = r_adr;
  assign tgt_wdata_o  = r_wdata;
  assign err_irq_o    = r_irq;
  assign err_status_o = r_status;

endmodule
`default_nettype wire
